// File: rtl/add8_and_mux8_pkg.sv
// Shared definitions for the add8_and_mux8 ALU slice: operation encoding and data width.
package add8_and_mux8_pkg;

    localparam int W = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOT  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

endpackage

// File: rtl/add8_and_mux8_add8.sv
// 8-bit ripple-carry adder shared by ADD and SUB in the add8_and_mux8 slice.
module add8
    import add8_and_mux8_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic carry;

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch can be inferred.
        sum   = '0;
        carry = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/add8_and_mux8.sv
// Registered 8-bit ALU slice: shared adder, bitwise units and an 8-way result mux.
// Optional zero/neg flag outputs are enabled by defining ADD8_AND_MUX8_FLAGS_EN.
module add8_and_mux8
    import add8_and_mux8_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic [2:0]   sel,
    output logic [W-1:0] out,
    output logic         cout,
`ifdef ADD8_AND_MUX8_FLAGS_EN
    output logic         zero,
    output logic         neg,
`endif
    output logic         out_valid
);

    op_e          op;
    logic         is_sub;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    logic [W-1:0] out_d, out_q;
    logic         cout_d, cout_q;
    logic         valid_q;

    assign op = op_e'(sel);

    // SUB is a + ~b + ~cin, so the carry out reads as "no borrow".
    assign is_sub  = (op == OP_SUB);
    assign add_b   = is_sub ? ~b : b;
    assign add_cin = is_sub ? ~cin : cin;

    add8 u_add8 (
        .a    (a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        out_d  = '0;
        cout_d = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                out_d  = add_sum;
                cout_d = add_cout;
            end
            OP_AND:  out_d = a & b;
            OP_OR:   out_d = a | b;
            OP_XOR:  out_d = a ^ b;
            OP_NOT:  out_d = ~a;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid_q <= in_valid;
            if (in_valid) begin
                out_q  <= out_d;
                cout_q <= cout_d;
            end
        end
    end

`ifdef ADD8_AND_MUX8_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (in_valid) begin
            zero_q <= (out_d == '0);
            neg_q  <= out_d[W-1];
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
`endif

    assign out       = out_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_add8_and_mux8.sv
// Self-checking bench for add8_and_mux8: directed vector table plus reset and hold sequences.
module tb_add8_and_mux8;
    import add8_and_mux8_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [2:0]   sel = 3'd0;
    logic [W-1:0] out;
    logic         cout;
    logic         out_valid;
`ifdef ADD8_AND_MUX8_FLAGS_EN
    logic         zero;
    logic         neg;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add8_and_mux8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sel       (sel),
        .out       (out),
        .cout      (cout),
`ifdef ADD8_AND_MUX8_FLAGS_EN
        .zero      (zero),
        .neg       (neg),
`endif
        .out_valid (out_valid)
    );

    typedef struct {
        string        name;
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_out;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, actual, actual, expected, expected);
        end
    endtask

    // Drive one operation on the falling edge; outputs are sampled 1 time unit after capture.
    task automatic apply(input op_e op, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic valid);
        @(negedge clk);
        sel      = op;
        a        = va;
        b        = vb;
        cin      = vcin;
        in_valid = valid;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{"add_5_3",      OP_ADD,  8'd5,   8'd3,   1'b0, 8'd8,   1'b0});
        vecs.push_back('{"sub_5_3",      OP_SUB,  8'd5,   8'd3,   1'b0, 8'd2,   1'b1});
        vecs.push_back('{"and_5_3",      OP_AND,  8'd5,   8'd3,   1'b0, 8'd1,   1'b0});
        vecs.push_back('{"or_5_3",       OP_OR,   8'd5,   8'd3,   1'b0, 8'd7,   1'b0});
        vecs.push_back('{"xor_5_3",      OP_XOR,  8'd5,   8'd3,   1'b0, 8'd6,   1'b0});
        vecs.push_back('{"not_5",        OP_NOT,  8'd5,   8'd3,   1'b0, 8'd250, 1'b0});
        vecs.push_back('{"add_wrap",     OP_ADD,  8'd255, 8'd1,   1'b0, 8'd0,   1'b1});
        vecs.push_back('{"add_cin",      OP_ADD,  8'd200, 8'd100, 1'b1, 8'd45,  1'b1});
        vecs.push_back('{"sub_borrow",   OP_SUB,  8'd3,   8'd5,   1'b0, 8'd254, 1'b0});
        vecs.push_back('{"sub_cin",      OP_SUB,  8'd10,  8'd3,   1'b1, 8'd6,   1'b1});
        vecs.push_back('{"sub_eq_cin",   OP_SUB,  8'd7,   8'd7,   1'b1, 8'd255, 1'b0});
        vecs.push_back('{"add_cin_only", OP_ADD,  8'd0,   8'd0,   1'b1, 8'd1,   1'b0});
        vecs.push_back('{"and_cin_ign",  OP_AND,  8'hF0,  8'h3C,  1'b1, 8'h30,  1'b0});
        vecs.push_back('{"rsv6",         OP_RSV6, 8'hFF,  8'hFF,  1'b1, 8'd0,   1'b0});
        vecs.push_back('{"rsv7",         OP_RSV7, 8'hAA,  8'h55,  1'b1, 8'd0,   1'b0});

        // Reset state before any clocks are accepted.
        #2;
        check("reset_out", out, 8'd0);
        check("reset_cout", {7'd0, cout}, 8'd0);
        check("reset_valid", {7'd0, out_valid}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            check({vecs[i].name, "_out"}, out, vecs[i].exp_out);
            check({vecs[i].name, "_cout"}, {7'd0, cout}, {7'd0, vecs[i].exp_cout});
            check({vecs[i].name, "_valid"}, {7'd0, out_valid}, 8'd1);
`ifdef ADD8_AND_MUX8_FLAGS_EN
            check({vecs[i].name, "_zero"}, {7'd0, zero}, {7'd0, (vecs[i].exp_out == 8'd0)});
            check({vecs[i].name, "_neg"}, {7'd0, neg}, {7'd0, vecs[i].exp_out[W-1]});
`endif
        end

        // Latency: result not visible before the capturing edge.
        @(negedge clk);
        sel = OP_ADD; a = 8'd20; b = 8'd22; cin = 1'b0; in_valid = 1'b1;
        #1;
        check("latency_pre_out", out, 8'd0);
        @(posedge clk);
        #1;
        check("latency_post_out", out, 8'd42);

        // Hold: dropping in_valid keeps result but clears out_valid, even with new inputs.
        apply(OP_OR, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("hold_out", out, 8'd42);
        check("hold_cout", {7'd0, cout}, 8'd0);
        check("hold_valid", {7'd0, out_valid}, 8'd0);
        apply(OP_NOT, 8'h00, 8'h00, 1'b0, 1'b0);
        check("hold2_out", out, 8'd42);

        // Mid-stream async reset clears outputs without waiting for an edge.
        apply(OP_ADD, 8'd255, 8'd1, 1'b0, 1'b1);
        check("pre_reset_cout", {7'd0, cout}, 8'd1);
        @(negedge clk);
        apply(OP_XOR, 8'h0F, 8'hF0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", out, 8'd0);
        check("async_reset_cout", {7'd0, cout}, 8'd0);
        check("async_reset_valid", {7'd0, out_valid}, 8'd0);
        @(posedge clk);
        #1;
        check("in_reset_out", out, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // First valid after release shows up one cycle later.
        apply(OP_SUB, 8'd100, 8'd1, 1'b0, 1'b1);
        check("post_reset_out", out, 8'd99);
        check("post_reset_cout", {7'd0, cout}, 8'd1);
        check("post_reset_valid", {7'd0, out_valid}, 8'd1);
        apply(OP_ADD, 8'd0, 8'd0, 1'b0, 1'b0);
        check("post_reset_drop_valid", {7'd0, out_valid}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
